// File: rtl/controle_multiciclo.sv
// Multicycle control FSM for the 8-bit processor: sequences fetch/decode/execute/memory/writeback
// over a shared ready-handshake memory, with wait-state timeout, resumable halt and retire counter.
module controle_multiciclo #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [2:0] opcode,
  input  logic       Zero,
  input  logic       mem_pronto,
  input  logic       continuar,
  output logic       EscIR,
  output logic       EscPC,
  output logic       EscReg,
  output logic       EscMEM,
  output logic       LerMEM,
  output logic       Ji,
  output logic       Beqz,
  output logic [1:0] ULAOp,
  output logic [1:0] ULAFonte,
  output logic       EndFonte_MEM,
  output logic       FonteEscReg,
  output logic       RegFonte,
  output logic       STOP,
  output logic       erro,
  output logic [2:0] estado,
  output logic [7:0] instr_count
);

  // state   | meaning
  // INICIO  | post-reset idle, one cycle
  // BUSCA   | instruction fetch, waits for mem_pronto
  // DECOD   | latch opcode, dispatch
  // EXEC    | ULA operation / branch / jump
  // MEM     | data read or write, waits for mem_pronto
  // ESCRITA | register file writeback
  // PARADO  | halted until continuar
  // ERRO    | memory timeout, terminal until reset
  typedef enum logic [2:0] {
    INICIO  = 3'b000,
    BUSCA   = 3'b001,
    DECOD   = 3'b010,
    EXEC    = 3'b011,
    MEM     = 3'b100,
    ESCRITA = 3'b101,
    PARADO  = 3'b110,
    ERRO    = 3'b111
  } state_t;

  localparam logic [2:0] OP_ADD    = 3'b000;
  localparam logic [2:0] OP_COPY   = 3'b001;
  localparam logic [2:0] OP_READ   = 3'b010;
  localparam logic [2:0] OP_WRITE  = 3'b011;
  localparam logic [2:0] OP_IFZERO = 3'b100;
  localparam logic [2:0] OP_JUMP   = 3'b101;
  localparam logic [2:0] OP_SET    = 3'b110;
  localparam logic [2:0] OP_STOP   = 3'b111;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_t     state, state_next;
  logic [2:0] op_reg;
  logic [7:0] wait_cnt;
  logic       retire;
  logic       timed_out;

  // a ready arriving on the terminal count still completes the handshake
  assign timed_out = (wait_cnt == TIMEOUT) && !mem_pronto;
  assign estado    = state;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= INICIO;
      op_reg      <= 3'b000;
      wait_cnt    <= 8'd0;
      instr_count <= 8'd0;
    end else begin
      state <= state_next;
      if (state == DECOD) op_reg <= opcode;
      if (state_next != state) wait_cnt <= 8'd0;
      else if ((state == BUSCA || state == MEM) && !mem_pronto) wait_cnt <= wait_cnt + 8'd1;
      if (retire) instr_count <= instr_count + 8'd1;
    end
  end

  always_comb begin
    state_next   = state;
    retire       = 1'b0;
    EscIR        = 1'b0;
    EscPC        = 1'b0;
    EscReg       = 1'b0;
    EscMEM       = 1'b0;
    LerMEM       = 1'b0;
    Ji           = 1'b0;
    Beqz         = 1'b0;
    ULAOp        = 2'b00;
    ULAFonte     = 2'b10;
    EndFonte_MEM = 1'b0;
    FonteEscReg  = 1'b0;
    RegFonte     = 1'b0;
    STOP         = 1'b0;
    erro         = 1'b0;
    case (state)
      INICIO: state_next = BUSCA;
      BUSCA: begin
        LerMEM = 1'b1;
        if (mem_pronto) begin
          EscIR      = 1'b1;
          EscPC      = 1'b1;
          state_next = DECOD;
        end else if (timed_out) begin
          state_next = ERRO;
        end
      end
      DECOD: begin
        if (opcode == OP_STOP) begin
          retire     = 1'b1;
          state_next = PARADO;
        end else begin
          state_next = EXEC;
        end
      end
      EXEC: begin
        case (op_reg)
          OP_ADD:  state_next = ESCRITA;
          OP_COPY: begin
            ULAFonte   = 2'b01;
            state_next = ESCRITA;
          end
          OP_READ, OP_WRITE: begin
            ULAFonte     = 2'b00;
            EndFonte_MEM = 1'b1;
            state_next   = MEM;
          end
          OP_IFZERO: begin
            ULAOp      = 2'b01;
            ULAFonte   = 2'b01;
            Beqz       = 1'b1;
            EscPC      = Zero;
            retire     = 1'b1;
            state_next = BUSCA;
          end
          OP_JUMP: begin
            Ji         = 1'b1;
            EscPC      = 1'b1;
            retire     = 1'b1;
            state_next = BUSCA;
          end
          OP_SET: begin
            ULAFonte   = 2'b00;
            state_next = ESCRITA;
          end
          default: state_next = BUSCA;
        endcase
      end
      MEM: begin
        EndFonte_MEM = 1'b1;
        ULAFonte     = 2'b00;
        if (op_reg == OP_WRITE) EscMEM = 1'b1;
        else LerMEM = 1'b1;
        if (mem_pronto) begin
          if (op_reg == OP_WRITE) begin
            retire     = 1'b1;
            state_next = BUSCA;
          end else begin
            state_next = ESCRITA;
          end
        end else if (timed_out) begin
          state_next = ERRO;
        end
      end
      ESCRITA: begin
        EscReg      = 1'b1;
        FonteEscReg = (op_reg == OP_SET);
        RegFonte    = (op_reg == OP_READ);
        retire      = 1'b1;
        state_next  = BUSCA;
      end
      PARADO: begin
        STOP = 1'b1;
        if (continuar) state_next = BUSCA;
      end
      ERRO: erro = 1'b1;
      default: state_next = INICIO;
    endcase
  end

endmodule

// File: tb/tb_controle_multiciclo.sv
// Scoreboard bench for controle_multiciclo: stimulus pushes hand-computed per-cycle expectations,
// a monitor pops and compares them on the falling edge (or immediately for async-reset checks).
module tb_controle_multiciclo;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [2:0] opcode;
  logic       Zero, mem_pronto, continuar;
  logic       EscIR, EscPC, EscReg, EscMEM, LerMEM, Ji, Beqz;
  logic [1:0] ULAOp, ULAFonte;
  logic       EndFonte_MEM, FonteEscReg, RegFonte, STOP, erro;
  logic [2:0] estado;
  logic [7:0] instr_count;

  controle_multiciclo #(.MEM_TIMEOUT(3)) dut (
    .clock(clock), .reset_n(reset_n), .opcode(opcode), .Zero(Zero),
    .mem_pronto(mem_pronto), .continuar(continuar),
    .EscIR(EscIR), .EscPC(EscPC), .EscReg(EscReg), .EscMEM(EscMEM), .LerMEM(LerMEM),
    .Ji(Ji), .Beqz(Beqz), .ULAOp(ULAOp), .ULAFonte(ULAFonte), .EndFonte_MEM(EndFonte_MEM),
    .FonteEscReg(FonteEscReg), .RegFonte(RegFonte), .STOP(STOP), .erro(erro),
    .estado(estado), .instr_count(instr_count)
  );

  always #5 clock = ~clock;

  // ctrl = {EscIR,EscPC,EscReg,EscMEM,LerMEM, Ji,Beqz, ULAOp, ULAFonte, EndFonte_MEM,FonteEscReg,RegFonte, STOP,erro}
  localparam logic [15:0] C_IDLE     = 16'b00000_00_00_10_000_00;
  localparam logic [15:0] C_BUSCA_W  = 16'b00001_00_00_10_000_00;
  localparam logic [15:0] C_BUSCA_OK = 16'b11001_00_00_10_000_00;
  localparam logic [15:0] C_EX_COPY  = 16'b00000_00_00_01_000_00;
  localparam logic [15:0] C_EX_RW    = 16'b00000_00_00_00_100_00;
  localparam logic [15:0] C_EX_IFZ1  = 16'b01000_01_01_01_000_00;
  localparam logic [15:0] C_EX_IFZ0  = 16'b00000_01_01_01_000_00;
  localparam logic [15:0] C_EX_JUMP  = 16'b01000_10_00_10_000_00;
  localparam logic [15:0] C_EX_SET   = 16'b00000_00_00_00_000_00;
  localparam logic [15:0] C_MEM_RD   = 16'b00001_00_00_00_100_00;
  localparam logic [15:0] C_MEM_WR   = 16'b00010_00_00_00_100_00;
  localparam logic [15:0] C_ESC_ULA  = 16'b00100_00_00_10_000_00;
  localparam logic [15:0] C_ESC_SET  = 16'b00100_00_00_10_010_00;
  localparam logic [15:0] C_ESC_RD   = 16'b00100_00_00_10_001_00;
  localparam logic [15:0] C_PARADO   = 16'b00000_00_00_10_000_10;
  localparam logic [15:0] C_ERRO     = 16'b00000_00_00_10_000_01;

  localparam logic [2:0] S_INI = 3'd0, S_BUS = 3'd1, S_DEC = 3'd2, S_EXE = 3'd3;
  localparam logic [2:0] S_MEM = 3'd4, S_ESC = 3'd5, S_PAR = 3'd6, S_ERR = 3'd7;

  typedef struct {
    logic [2:0]  es;
    logic [15:0] ctrl;
    logic [7:0]  cnt;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  event chk_now;

  task automatic push(input logic [2:0] es, input logic [15:0] ct, input logic [7:0] ic,
                      input string nm);
    exp_t e;
    e.es = es; e.ctrl = ct; e.cnt = ic; e.name = nm;
    sb.push_back(e);
  endtask

  // one clock cycle: apply inputs, record what the DUT must show during this cycle
  task automatic cyc(input logic [2:0] op, input logic z, input logic p, input logic c,
                     input logic [2:0] es, input logic [15:0] ct, input logic [7:0] ic,
                     input string nm);
    opcode = op; Zero = z; mem_pronto = p; continuar = c;
    push(es, ct, ic, nm);
    @(posedge clock);
    #1;
  endtask

  initial begin : monitor
    exp_t        e;
    logic [15:0] got;
    forever begin
      @(negedge clock or chk_now);
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        got = {EscIR, EscPC, EscReg, EscMEM, LerMEM, Ji, Beqz, ULAOp, ULAFonte,
               EndFonte_MEM, FonteEscReg, RegFonte, STOP, erro};
        total++;
        if (estado !== e.es || got !== e.ctrl || instr_count !== e.cnt) begin
          bad++;
          $display("FAIL %s: got estado=%0d ctrl=%b cnt=%0d, want estado=%0d ctrl=%b cnt=%0d",
                   e.name, estado, got, instr_count, e.es, e.ctrl, e.cnt);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    reset_n = 1'b0; opcode = 3'b000; Zero = 1'b0; mem_pronto = 1'b0; continuar = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    push(S_INI, C_IDLE, 8'd0, "reset_state");
    -> chk_now;
    #1 reset_n = 1'b1;

    // ADD, zero-wait
    cyc(3'b000, 0, 1, 0, S_INI, C_IDLE,     8'd0, "add_inicio");
    cyc(3'b000, 0, 1, 0, S_BUS, C_BUSCA_OK, 8'd0, "add_busca");
    cyc(3'b000, 0, 1, 0, S_DEC, C_IDLE,     8'd0, "add_decod");
    cyc(3'b000, 0, 1, 0, S_EXE, C_IDLE,     8'd0, "add_exec");
    cyc(3'b000, 0, 1, 0, S_ESC, C_ESC_ULA,  8'd0, "add_escrita");
    // READ with two wait cycles in MEM
    cyc(3'b010, 0, 1, 0, S_BUS, C_BUSCA_OK, 8'd1, "rd_busca");
    cyc(3'b010, 0, 1, 0, S_DEC, C_IDLE,     8'd1, "rd_decod");
    cyc(3'b010, 0, 1, 0, S_EXE, C_EX_RW,    8'd1, "rd_exec");
    cyc(3'b010, 0, 0, 0, S_MEM, C_MEM_RD,   8'd1, "rd_mem_w1");
    cyc(3'b010, 0, 0, 0, S_MEM, C_MEM_RD,   8'd1, "rd_mem_w2");
    cyc(3'b010, 0, 1, 0, S_MEM, C_MEM_RD,   8'd1, "rd_mem_ok");
    cyc(3'b010, 0, 1, 0, S_ESC, C_ESC_RD,   8'd1, "rd_escrita");
    // IFZERO taken / not taken
    cyc(3'b100, 1, 1, 0, S_BUS, C_BUSCA_OK, 8'd2, "ifz1_busca");
    cyc(3'b100, 1, 1, 0, S_DEC, C_IDLE,     8'd2, "ifz1_decod");
    cyc(3'b100, 1, 1, 0, S_EXE, C_EX_IFZ1,  8'd2, "ifz1_exec");
    cyc(3'b100, 0, 1, 0, S_BUS, C_BUSCA_OK, 8'd3, "ifz0_busca");
    cyc(3'b100, 0, 1, 0, S_DEC, C_IDLE,     8'd3, "ifz0_decod");
    cyc(3'b100, 0, 1, 0, S_EXE, C_EX_IFZ0,  8'd3, "ifz0_exec");
    // JUMP
    cyc(3'b101, 1, 1, 0, S_BUS, C_BUSCA_OK, 8'd4, "jmp_busca");
    cyc(3'b101, 1, 1, 0, S_DEC, C_IDLE,     8'd4, "jmp_decod");
    cyc(3'b101, 1, 1, 0, S_EXE, C_EX_JUMP,  8'd4, "jmp_exec");
    // SET
    cyc(3'b110, 0, 1, 0, S_BUS, C_BUSCA_OK, 8'd5, "set_busca");
    cyc(3'b110, 0, 1, 0, S_DEC, C_IDLE,     8'd5, "set_decod");
    cyc(3'b110, 0, 1, 0, S_EXE, C_EX_SET,   8'd5, "set_exec");
    cyc(3'b110, 0, 1, 0, S_ESC, C_ESC_SET,  8'd5, "set_escrita");
    // COPY
    cyc(3'b001, 0, 1, 0, S_BUS, C_BUSCA_OK, 8'd6, "cpy_busca");
    cyc(3'b001, 0, 1, 0, S_DEC, C_IDLE,     8'd6, "cpy_decod");
    cyc(3'b001, 0, 1, 0, S_EXE, C_EX_COPY,  8'd6, "cpy_exec");
    cyc(3'b001, 0, 1, 0, S_ESC, C_ESC_ULA,  8'd6, "cpy_escrita");
    // WRITE, zero-wait
    cyc(3'b011, 0, 1, 0, S_BUS, C_BUSCA_OK, 8'd7, "wr_busca");
    cyc(3'b011, 0, 1, 0, S_DEC, C_IDLE,     8'd7, "wr_decod");
    cyc(3'b011, 0, 1, 0, S_EXE, C_EX_RW,    8'd7, "wr_exec");
    cyc(3'b011, 0, 1, 0, S_MEM, C_MEM_WR,   8'd7, "wr_mem");
    // STOP; continuar outside PARADO is ignored
    cyc(3'b111, 0, 1, 1, S_BUS, C_BUSCA_OK, 8'd8, "stop_busca_cont");
    cyc(3'b111, 0, 1, 1, S_DEC, C_IDLE,     8'd8, "stop_decod");
    for (int i = 0; i < 5; i++)
      cyc(3'b000, 0, 1, 0, S_PAR, C_PARADO, 8'd9, "stop_parado");
    cyc(3'b000, 0, 1, 1, S_PAR, C_PARADO,   8'd9, "stop_resume");
    // fetch wait: ready on the terminal count still completes
    for (int i = 0; i < 3; i++)
      cyc(3'b000, 0, 0, 0, S_BUS, C_BUSCA_W, 8'd9, "to_edge_wait");
    cyc(3'b000, 0, 1, 0, S_BUS, C_BUSCA_OK, 8'd9, "to_edge_ok");
    cyc(3'b000, 0, 1, 0, S_DEC, C_IDLE,     8'd9, "to_edge_decod");
    cyc(3'b000, 0, 1, 0, S_EXE, C_IDLE,     8'd9, "to_edge_exec");
    cyc(3'b000, 0, 1, 0, S_ESC, C_ESC_ULA,  8'd9, "to_edge_escrita");
    // reset mid-WRITE while EscMEM is high
    cyc(3'b011, 0, 1, 0, S_BUS, C_BUSCA_OK, 8'd10, "wrst_busca");
    cyc(3'b011, 0, 1, 0, S_DEC, C_IDLE,     8'd10, "wrst_decod");
    cyc(3'b011, 0, 1, 0, S_EXE, C_EX_RW,    8'd10, "wrst_exec");
    opcode = 3'b011; mem_pronto = 1'b0;
    push(S_MEM, C_MEM_WR, 8'd10, "wrst_mem");
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    push(S_INI, C_IDLE, 8'd0, "wrst_async");
    -> chk_now;
    @(posedge clock);
    #1 reset_n = 1'b1;
    // fetch timeout into ERRO, continuar ignored there
    cyc(3'b000, 0, 0, 0, S_INI, C_IDLE, 8'd0, "err_inicio");
    for (int i = 0; i < 4; i++)
      cyc(3'b000, 0, 0, 0, S_BUS, C_BUSCA_W, 8'd0, "err_busca_wait");
    cyc(3'b000, 0, 0, 1, S_ERR, C_ERRO, 8'd0, "err_cont");
    cyc(3'b000, 0, 1, 0, S_ERR, C_ERRO, 8'd0, "err_sticky");
    reset_n = 1'b0;
    #1;
    push(S_INI, C_IDLE, 8'd0, "err_reset_clear");
    -> chk_now;
    @(negedge clock);
    #1;
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/controle_multiciclo.md
Name: controle_multiciclo

Overview:
- Multicycle control FSM for the 8-bit processor. It sequences each instruction through fetch, decode, execute, memory and writeback states.
- It drives the ULA, register file, PC and a shared instruction/data memory that has a ready handshake.
- It replaces single-cycle decode with per-state control, adds memory wait states with a timeout, a resumable halt, and a retired-instruction counter.

Parameters:
MEM_TIMEOUT, 15, wait cycles without mem_pronto before entering ERRO (1..255)

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
opcode  in  3  instruction opcode from IR, sampled in DECOD
Zero  in  1  ULA zero flag, used in EXEC of IFZERO
mem_pronto  in  1  memory ready: read data valid / write accepted this cycle
continuar  in  1  resume pulse, honoured only in PARADO
EscIR  out  1  IR load enable
EscPC  out  1  PC load enable
EscReg  out  1  register file write enable
EscMEM  out  1  memory write request
LerMEM  out  1  memory read request
Ji  out  1  PC source = jump target
Beqz  out  1  PC source = branch target
ULAOp  out  2  ULA operation (00 add, 01 cmp)
ULAFonte  out  2  ULA B source (00 short imm, 01 zero, 10 register)
EndFonte_MEM  out  1  memory address = ULA result (1) / PC (0)
FonteEscReg  out  1  writeback from immediate (1) / ULA (0)
RegFonte  out  1  writeback from memory (1)
STOP  out  1  processor halted
erro  out  1  memory timeout fault, sticky
estado  out  3  current state, debug
instr_count  out  8  retired instructions, wraps 255->0

Behaviour:
- Asynchronous reset (reset_n=0) forces state INICIO, timeout counter 0, instr_count 0 and op_reg 000.
- All outputs are 0 in reset and in INICIO, except ULAFonte=10 and estado=000. Reset mid-operation aborts immediately; EscMEM/LerMEM drop asynchronously.
- State encoding: INICIO 000, BUSCA 001, DECOD 010, EXEC 011, MEM 100, ESCRITA 101, PARADO 110, ERRO 111.
- Defaults in every state: all enables 0, ULAOp 00, ULAFonte 10. Outputs are decoded combinationally from state and op_reg; EscIR and EscPC also depend on the inputs listed below.
- INICIO: go to BUSCA after 1 cycle.
- BUSCA: LerMEM=1, EndFonte_MEM=0. When mem_pronto=1: EscIR=1, EscPC=1 (PC+1), next state DECOD. Otherwise stay and count.
- DECOD: op_reg<=opcode. If opcode=111, go to PARADO; else go to EXEC.
- EXEC by op_reg:
  - 000 ADD: ULAOp 00, ULAFonte 10, then ESCRITA.
  - 001 COPY: ULAFonte 01, then ESCRITA.
  - 010 READ: ULAFonte 00, EndFonte_MEM 1, then MEM.
  - 011 WRITE: ULAFonte 00, EndFonte_MEM 1, then MEM.
  - 100 IFZERO: ULAOp 01, ULAFonte 01, Beqz 1, EscPC=Zero; retire, then BUSCA.
  - 101 JUMP: Ji 1, EscPC 1; retire, then BUSCA.
  - 110 SET: ULAFonte 00, then ESCRITA.
- MEM: EndFonte_MEM 1, ULAFonte 00. READ holds LerMEM=1; WRITE holds EscMEM=1. Both stay until mem_pronto=1.
  - READ then goes to ESCRITA.
  - WRITE retires, then goes to BUSCA.
- ESCRITA: EscReg=1 for 1 cycle, then retire and go to BUSCA.
  - ADD/COPY: FonteEscReg 0, RegFonte 0.
  - SET: FonteEscReg 1.
  - READ: RegFonte 1.
- Retire: instr_count+1 on the exiting edge. STOP counts as retired on the entry to PARADO.
- PARADO: STOP=1, all write enables 0. If continuar=1 at a clock edge, go to BUSCA; continuar is ignored in every other state.
- Timeout counter:
  - Increments each cycle in BUSCA or MEM with mem_pronto=0; clears on any state change.
  - At count == MEM_TIMEOUT with mem_pronto still 0, the next state is ERRO. mem_pronto=1 in that same cycle wins and the handshake completes normally.
- ERRO: erro=1, all enables 0, STOP 0. Terminal until reset; continuar is ignored.
- Latency with zero-wait memory: ADD/COPY/SET 4 cycles, READ 5, WRITE 4, IFZERO/JUMP 3, STOP 2 cycles to PARADO. Each wait cycle adds 1.

Test Plan:
- Reset release, opcode=000, mem_pronto=1 constantly -> estado 000,001,010,011,101,001; EscIR/EscPC high 1 cycle in BUSCA; EscReg high only in ESCRITA; instr_count=1.
- READ (010) with mem_pronto low 2 cycles in MEM -> LerMEM held 3 cycles in MEM with EndFonte_MEM=1; RegFonte=1 and EscReg=1 in ESCRITA; total 7 cycles BUSCA-to-BUSCA.
- IFZERO with Zero=1, then with Zero=0 -> EscPC=1/Beqz=1 in EXEC for the first, EscPC=0 for the second; both 3 cycles; instr_count +2.
- STOP (111) then continuar pulse after 5 cycles -> STOP=1 in PARADO, continuar ignored during BUSCA, then return to BUSCA on the pulse edge; instr_count incremented once for STOP.
- MEM_TIMEOUT=3, mem_pronto held 0 in BUSCA -> ERRO after 4 cycles; erro=1 and LerMEM=0; a continuar pulse does nothing; reset_n low clears erro.
- Assert reset_n low mid-WRITE while EscMEM=1 -> EscMEM drops immediately without a clock edge; estado=000 and instr_count=0.
